// File: rtl/seven_seg_scan_reader_if.sv
// Bus between a multiplexed 7-segment driver and the scan reader.
// The slave side is the reader; the master side drives the segment lines and observes the results.
interface seven_seg_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              i_seg;          // {a,b,c,d,e,f,g}, 1 = lit
    logic [NUM_DIGITS-1:0]   i_an;           // digit enables, one-hot when valid
    logic [4*NUM_DIGITS-1:0] o_digits;       // last captured value per digit
    logic [NUM_DIGITS-1:0]   o_digit_seen;   // digit captured since last frame
    logic [NUM_DIGITS-1:0]   o_digit_err;    // last capture was blank / non-hex
    logic [4*NUM_DIGITS-1:0] o_frame_digits; // snapshot at frame completion
    logic                    o_frame_err;    // any digit in error at snapshot
    logic                    o_frame_done;   // one-cycle frame pulse

    modport slave (
        input  i_seg, i_an,
        output o_digits, o_digit_seen, o_digit_err,
               o_frame_digits, o_frame_err, o_frame_done
    );

    modport master (
        output i_seg, i_an,
        input  o_digits, o_digit_seen, o_digit_err,
               o_frame_digits, o_frame_err, o_frame_done
    );
endinterface

// File: rtl/seven_seg_scan_reader.sv
// Readback of a multiplexed 7-segment display: debounces each {seg,an} pattern,
// decodes it to hex and assembles a frame once every digit has been captured.
module seven_seg_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    seven_seg_scan_reader_if.slave    bus
);
    localparam int              CW   = $clog2(STABLE_CYCLES + 1);
    localparam int              SW   = 7 + NUM_DIGITS;
    localparam logic [CW-1:0]   STAB = CW'(STABLE_CYCLES);

    typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

    // Returns {valid, value}; valid=0 for blank or any non-hex pattern.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'h7E: f_decode = 5'h10;
            7'h30: f_decode = 5'h11;
            7'h6D: f_decode = 5'h12;
            7'h79: f_decode = 5'h13;
            7'h33: f_decode = 5'h14;
            7'h5B: f_decode = 5'h15;
            7'h5F: f_decode = 5'h16;
            7'h70: f_decode = 5'h17;
            7'h7F: f_decode = 5'h18;
            7'h7B: f_decode = 5'h19;
            7'h77: f_decode = 5'h1A;
            7'h1F: f_decode = 5'h1B;
            7'h4E: f_decode = 5'h1C;
            7'h3D: f_decode = 5'h1D;
            7'h4F: f_decode = 5'h1E;
            7'h47: f_decode = 5'h1F;
            default: f_decode = 5'h00;
        endcase
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [SW-1:0]           r_samp;
    logic [CW-1:0]           r_cnt;
    logic [4*NUM_DIGITS-1:0] r_digits, r_frame_digits;
    logic [NUM_DIGITS-1:0]   r_seen, r_err;
    logic                    r_frame_err;

    logic [SW-1:0]           w_in;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_cap;
    logic                    w_onehot;
    logic                    w_cap_ok;
    logic [4:0]              w_dec;
    logic [4*NUM_DIGITS-1:0] w_digits_nxt;
    logic [NUM_DIGITS-1:0]   w_seen_nxt, w_err_nxt;
    logic                    w_fire;

    assign w_in     = {bus.i_seg, bus.i_an};
    assign w_onehot = (bus.i_an != '0) && ((bus.i_an & (bus.i_an - 1'b1)) == '0);
    assign w_dec    = f_decode(bus.i_seg);

    // Stability counter: saturating run length of identical samples. Capture fires only
    // on the edge the count first reaches STAB, so a held pattern is taken exactly once.
    always_comb begin
        w_cnt_nxt = CW'(1);
        w_cap     = 1'b0;
        if (w_in == r_samp)
            w_cnt_nxt = (r_cnt == STAB) ? STAB : r_cnt + 1'b1;
        if (w_cnt_nxt == STAB && (w_in != r_samp || r_cnt != STAB))
            w_cap = 1'b1;
    end

    assign w_cap_ok = w_cap && w_onehot;

    // Per-digit update for a valid capture; the frame snapshot sees these updated values.
    always_comb begin
        w_digits_nxt = r_digits;
        w_err_nxt    = r_err;
        w_seen_nxt   = r_seen;
        if (w_cap_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.i_an[i]) begin
                    if (w_dec[4]) begin
                        w_digits_nxt[4*i +: 4] = w_dec[3:0];
                        w_err_nxt[i]           = 1'b0;
                    end else begin
                        w_err_nxt[i]           = 1'b1;
                    end
                    w_seen_nxt[i] = 1'b1;
                end
            end
        end
    end

    // Frame FSM next state: completion only counts from COLLECT; DONE is a single cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_cap_ok && (&w_seen_nxt)) begin
                    w_fire      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= COLLECT;
        else         r_state <= w_state_nxt;
    end

    // Sampler, digit store and frame snapshot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_samp         <= '0;
            r_cnt          <= '0;
            r_digits       <= '0;
            r_err          <= '0;
            r_seen         <= '0;
            r_frame_digits <= '0;
            r_frame_err    <= 1'b0;
        end else begin
            r_samp   <= w_in;
            r_cnt    <= w_cnt_nxt;
            r_digits <= w_digits_nxt;
            r_err    <= w_err_nxt;
            if (w_fire) begin
                r_seen         <= '0;
                r_frame_digits <= w_digits_nxt;
                r_frame_err    <= |w_err_nxt;
            end else begin
                r_seen         <= w_seen_nxt;
            end
        end
    end

    assign bus.o_digits       = r_digits;
    assign bus.o_digit_seen   = r_seen;
    assign bus.o_digit_err    = r_err;
    assign bus.o_frame_digits = r_frame_digits;
    assign bus.o_frame_err    = r_frame_err;
    assign bus.o_frame_done   = (r_state == DONE);
endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Directed bench for seven_seg_scan_reader (NUM_DIGITS=4, STABLE_CYCLES=8).
module tb_seven_seg_scan_reader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    seven_seg_scan_reader_if #(.NUM_DIGITS(4)) bus ();

    seven_seg_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses away from the active edge.
    always @(negedge clk) if (bus.o_frame_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern just after an edge and hold it for n rising edges.
    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
        bus.i_seg = s;
        bus.i_an  = a;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_seg = 7'h7F;
        bus.i_an  = 4'b0001;
        // 1: reset
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", 32'(bus.o_digits), 32'h0);
        chk("rst_seen", 32'(bus.o_digit_seen), 32'h0);
        chk("rst_err", 32'(bus.o_digit_err), 32'h0);
        chk("rst_fdig", 32'(bus.o_frame_digits), 32'h0);
        chk("rst_ferr", 32'(bus.o_frame_err), 32'h0);
        chk("rst_fdone", 32'(bus.o_frame_done), 32'h0);
        reset = 1'b0;

        // 2: stability threshold
        hold(7'h79, 4'b0001, 7);
        chk("stab7_digits", 32'(bus.o_digits), 32'h0);
        chk("stab7_seen", 32'(bus.o_digit_seen), 32'h0);
        hold(7'h00, 4'b0000, 1);
        hold(7'h79, 4'b0001, 8);
        chk("stab8_digits", 32'(bus.o_digits), 32'h0003);
        chk("stab8_seen", 32'(bus.o_digit_seen), 32'h1);
        chk("stab8_err", 32'(bus.o_digit_err), 32'h0);

        // 3: full frame
        hold(7'h30, 4'b0001, 8);
        hold(7'h6D, 4'b0010, 8);
        hold(7'h79, 4'b0100, 8);
        chk("f1_nodone_yet", 32'(done_cnt), 32'd0);
        hold(7'h33, 4'b1000, 8);
        chk("f1_done", 32'(bus.o_frame_done), 32'h1);
        chk("f1_fdig", 32'(bus.o_frame_digits), 32'h4321);
        chk("f1_ferr", 32'(bus.o_frame_err), 32'h0);
        chk("f1_seen", 32'(bus.o_digit_seen), 32'h0);
        hold(7'h00, 4'b0000, 1);
        chk("f1_pulse_end", 32'(bus.o_frame_done), 32'h0);
        chk("f1_cnt", 32'(done_cnt), 32'd1);

        // 4: error capture and recovery
        hold(7'h00, 4'b0010, 8);
        chk("err_blank", 32'(bus.o_digit_err), 32'h2);
        chk("err_held", 32'(bus.o_digits), 32'h4321);
        hold(7'h4E, 4'b0010, 8);
        chk("err_clr", 32'(bus.o_digit_err), 32'h0);
        chk("err_C", 32'(bus.o_digits), 32'h43C1);
        hold(7'h00, 4'b0010, 8);
        hold(7'h30, 4'b0001, 8);
        hold(7'h79, 4'b0100, 8);
        hold(7'h33, 4'b1000, 8);
        chk("f2_done", 32'(bus.o_frame_done), 32'h1);
        chk("f2_fdig", 32'(bus.o_frame_digits), 32'h43C1);
        chk("f2_ferr", 32'(bus.o_frame_err), 32'h1);
        hold(7'h00, 4'b0000, 1);
        chk("f2_cnt", 32'(done_cnt), 32'd2);

        // 5: invalid enables ignored
        hold(7'h7E, 4'b0000, 20);
        hold(7'h7E, 4'b0011, 20);
        chk("bad_digits", 32'(bus.o_digits), 32'h43C1);
        chk("bad_seen", 32'(bus.o_digit_seen), 32'h0);
        chk("bad_err", 32'(bus.o_digit_err), 32'h2);
        chk("bad_cnt", 32'(done_cnt), 32'd2);

        // 6: reset mid-frame
        hold(7'h30, 4'b0001, 8);
        hold(7'h6D, 4'b0010, 8);
        hold(7'h79, 4'b0100, 8);
        chk("mid_seen", 32'(bus.o_digit_seen), 32'h7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_seen", 32'(bus.o_digit_seen), 32'h0);
        chk("mid_rst_digits", 32'(bus.o_digits), 32'h0);
        chk("mid_rst_fdig", 32'(bus.o_frame_digits), 32'h0);
        hold(7'h33, 4'b1000, 8);
        chk("mid_4th_done", 32'(bus.o_frame_done), 32'h0);
        chk("mid_4th_seen", 32'(bus.o_digit_seen), 32'h8);
        chk("mid_4th_digits", 32'(bus.o_digits), 32'h4000);
        hold(7'h30, 4'b0001, 8);
        hold(7'h6D, 4'b0010, 8);
        chk("mid_cnt", 32'(done_cnt), 32'd2);
        hold(7'h79, 4'b0100, 8);
        chk("f3_done", 32'(bus.o_frame_done), 32'h1);
        chk("f3_fdig", 32'(bus.o_frame_digits), 32'h4321);
        chk("f3_ferr", 32'(bus.o_frame_err), 32'h0);
        hold(7'h00, 4'b0000, 2);
        chk("f3_cnt", 32'(done_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
